// File: rtl/hazard_grid_accum.sv
// hazard_grid_accum: rasterises per-frame bounding boxes into a ROWS x COLS occupancy grid.
// Optional per-frame hazard limit enabled with `define HAZARD_LIMIT_EN.
module hazard_grid_accum #(
    parameter int ROWS    = 4,
    parameter int COLS    = 8,
    parameter int CELL_W  = 3,
    parameter int CELL_H  = 2,
    parameter int COORD_W = 5,
    parameter int MAX_HAZ = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_start,
    input  logic                         frame_end,
    input  logic                         box_valid,
    output logic                         box_ready,
    input  logic [COORD_W-1:0]           box_top,
    input  logic [COORD_W-1:0]           box_left,
    input  logic [COORD_W-1:0]           box_bottom,
    input  logic [COORD_W-1:0]           box_right,
    output logic                         busy,
    output logic                         grid_valid,
    output logic [ROWS*COLS-1:0]         grid,
    output logic                         bad_box,
    output logic [$clog2(MAX_HAZ+1)-1:0] hazard_count,
    output logic                         hazard_ovf
);

    localparam int HC_W = $clog2(MAX_HAZ+1);
    localparam logic [31:0] CW32 = CELL_W;
    localparam logic [31:0] CH32 = CELL_H;
    localparam logic [31:0] CMAX = COLS - 1;
    localparam logic [31:0] RMAX = ROWS - 1;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_nx;
    logic   drain_cnt;

    logic xfer, bad, drop, accept;

    logic [31:0] cl, ch, rl, rh;

    logic               s1_valid;
    logic [COORD_W-1:0] s1_col_lo, s1_col_hi;
    logic [COORD_W-1:0] s1_row_lo, s1_row_hi;

    logic [ROWS*COLS-1:0] mask;
    logic [ROWS*COLS-1:0] acc;

    assign bad    = (box_left > box_right) || (box_top > box_bottom);
    assign xfer   = box_valid && box_ready && !frame_start;
    assign accept = xfer && !bad && !drop;

    // Next state and state-decoded handshake outputs; frame_start overrides all.
    always_comb begin
        state_nx  = state;
        box_ready = (state == COLLECT);
        busy      = (state == COLLECT) || (state == DRAIN);
        if (frame_start) begin
            state_nx = COLLECT;
        end else begin
            unique case (state)
                IDLE:    state_nx = IDLE;
                COLLECT: if (frame_end) state_nx = DRAIN;
                DRAIN:   if (drain_cnt) state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Two-cycle drain so the last box leaves stage 2 before the copy.
    always_ff @(posedge clk) begin
        if (rst || frame_start || state != DRAIN) drain_cnt <= 1'b0;
        else                                      drain_cnt <= 1'b1;
    end

    // Pixel-to-cell conversion, upper bounds clamped to the grid edge.
    always_comb begin
        cl = 32'(box_left) / CW32;
        ch = 32'(box_right) / CW32;
        rl = 32'(box_top) / CH32;
        rh = 32'(box_bottom) / CH32;
        if (ch > CMAX) ch = CMAX;
        if (rh > RMAX) rh = RMAX;
    end

    // Stage 1: register cell bounds of an accepted, well-formed box.
    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            s1_valid  <= 1'b0;
            s1_col_lo <= '0;
            s1_col_hi <= '0;
            s1_row_lo <= '0;
            s1_row_hi <= '0;
        end else begin
            s1_valid <= accept;
            if (xfer) begin
                s1_col_lo <= COORD_W'(cl);
                s1_col_hi <= COORD_W'(ch);
                s1_row_lo <= COORD_W'(rl);
                s1_row_hi <= COORD_W'(rh);
            end
        end
    end

    // Malformed boxes are flagged one cycle after transfer.
    always_ff @(posedge clk) begin
        if (rst || frame_start) bad_box <= 1'b0;
        else                    bad_box <= xfer && bad;
    end

    // Cells covered by the stage-1 rectangle; an out-of-grid start matches nothing.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam logic [31:0] RI = r;
            localparam logic [31:0] CI = c;
            assign mask[r*COLS+c] = (RI >= 32'(s1_row_lo)) &&
                                    (RI <= 32'(s1_row_hi)) &&
                                    (CI >= 32'(s1_col_lo)) &&
                                    (CI <= 32'(s1_col_hi));
        end
    end

    // Stage 2: OR the rectangle into the frame accumulator.
    always_ff @(posedge clk) begin
        if (rst || frame_start) acc <= '0;
        else if (s1_valid)      acc <= acc | mask;
    end

    // Publish the finished frame; grid holds until the next publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            grid       <= '0;
            grid_valid <= 1'b0;
        end else begin
            grid_valid <= (state == DONE) && !frame_start;
            if ((state == DONE) && !frame_start) grid <= acc;
        end
    end

`ifdef HAZARD_LIMIT_EN
    logic [HC_W-1:0] hcnt;
    logic            hovf;

    assign drop         = (hcnt == HC_W'(MAX_HAZ));
    assign hazard_count = hcnt;
    assign hazard_ovf   = hovf;

    // Saturating per-frame count of well-formed boxes; excess ones are dropped.
    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            hcnt <= '0;
            hovf <= 1'b0;
        end else if (xfer && !bad) begin
            if (drop) hovf <= 1'b1;
            else      hcnt <= hcnt + HC_W'(1);
        end
    end
`else
    assign drop         = 1'b0;
    assign hazard_count = '0;
    assign hazard_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_grid_accum.sv
// tb_hazard_grid_accum: directed frames with a queued scoreboard.
// Monitor checks grid_valid and bad_box pulses against expectations.
module tb_hazard_grid_accum;

    localparam int ROWS    = 4;
    localparam int COLS    = 8;
    localparam int COORD_W = 5;
    localparam int MAX_HAZ = 16;
    localparam int HC_W    = $clog2(MAX_HAZ+1);
`ifdef HAZARD_LIMIT_EN
    localparam bit HL = 1'b1;
`else
    localparam bit HL = 1'b0;
`endif

    logic                 clk;
    logic                 rst;
    logic                 frame_start;
    logic                 frame_end;
    logic                 box_valid;
    logic                 box_ready;
    logic [COORD_W-1:0]   box_top, box_left, box_bottom, box_right;
    logic                 busy;
    logic                 grid_valid;
    logic [ROWS*COLS-1:0] grid;
    logic                 bad_box;
    logic [HC_W-1:0]      hazard_count;
    logic                 hazard_ovf;

    hazard_grid_accum #(
        .ROWS(ROWS), .COLS(COLS), .CELL_W(3), .CELL_H(2),
        .COORD_W(COORD_W), .MAX_HAZ(MAX_HAZ)
    ) dut (
        .clk(clk), .rst(rst),
        .frame_start(frame_start), .frame_end(frame_end),
        .box_valid(box_valid), .box_ready(box_ready),
        .box_top(box_top), .box_left(box_left),
        .box_bottom(box_bottom), .box_right(box_right),
        .busy(busy), .grid_valid(grid_valid), .grid(grid),
        .bad_box(bad_box), .hazard_count(hazard_count),
        .hazard_ovf(hazard_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] grid;
        int          hc;
        bit          ovf;
        int          at;
        int          id;
    } exp_t;

    exp_t exq[$];
    int   bq[$];
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: every output pulse is matched against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        int   bc;
        if (grid_valid) begin
            if (exq.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL spurious_grid_valid: got 1 at cycle %0d want 0", cyc);
            end else begin
                e = exq.pop_front();
                chk($sformatf("frame%0d_grid", e.id), grid, e.grid);
                chk($sformatf("frame%0d_cycle", e.id), cyc, e.at);
                chk($sformatf("frame%0d_hcount", e.id), 32'(hazard_count), e.hc);
                chk($sformatf("frame%0d_hovf", e.id), 32'(hazard_ovf), 32'(e.ovf));
            end
        end
        if (bad_box) begin
            if (bq.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL spurious_bad_box: got 1 at cycle %0d want 0", cyc);
            end else begin
                bc = bq.pop_front();
                chk("bad_box_cycle", cyc, bc);
            end
        end
    end

    task automatic fs_pulse();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic send_box(int t, int l, int b, int r);
        @(negedge clk);
        box_top    = COORD_W'(t);
        box_left   = COORD_W'(l);
        box_bottom = COORD_W'(b);
        box_right  = COORD_W'(r);
        box_valid  = 1'b1;
        if (l > r || t > b) bq.push_back(cyc + 1);
        @(negedge clk);
        box_valid = 1'b0;
    endtask

    task automatic fe_pulse(int id, logic [31:0] g, int hc, bit ovf);
        exp_t e;
        @(negedge clk);
        frame_end = 1'b1;
        e.grid = g;
        e.hc   = hc;
        e.ovf  = ovf;
        e.at   = cyc + 4;
        e.id   = id;
        exq.push_back(e);
        @(negedge clk);
        frame_end = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        frame_end = 1'b0;
        box_valid = 1'b0;
        box_top = '0;
        box_left = '0;
        box_bottom = '0;
        box_right = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_grid", grid, 32'h0);
        chk("rst_grid_valid", 32'(grid_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_box_ready", 32'(box_ready), 32'h0);
        chk("rst_bad_box", 32'(bad_box), 32'h0);
        chk("rst_hcount", 32'(hazard_count), 32'h0);
        chk("rst_hovf", 32'(hazard_ovf), 32'h0);

        fs_pulse();
        chk("collect_busy", 32'(busy), 32'h1);
        chk("collect_ready", 32'(box_ready), 32'h1);
        send_box(0, 0, 5, 5);
        send_box(2, 15, 7, 25);
        fe_pulse(1, 32'hE0E3E303, HL ? 2 : 0, 1'b0);

        fs_pulse();
        send_box(0, 0, 31, 31);
        chk("grid_hold", grid, 32'hE0E3E303);
        fe_pulse(2, 32'hFFFFFFFF, HL ? 1 : 0, 1'b0);

        fs_pulse();
        send_box(4, 9, 1, 2);
        fe_pulse(3, 32'h0, 0, 1'b0);

        fs_pulse();
        fe_pulse(4, 32'h0, 0, 1'b0);

        fs_pulse();
        @(negedge clk);
        box_top = 5'd5;
        box_left = 5'd5;
        box_bottom = 5'd7;
        box_right = 5'd7;
        box_valid = 1'b1;
        @(negedge clk);
        box_valid = 1'b0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        send_box(0, 0, 0, 0);
        fe_pulse(5, 32'h1, HL ? 1 : 0, 1'b0);

        fs_pulse();
        for (int i = 0; i < 17; i++) send_box(0, 0, 0, 0);
        fe_pulse(6, 32'h1, HL ? 16 : 0, HL);

        fs_pulse();
        send_box(0, 0, 31, 31);
        @(negedge clk);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("drain_rst_grid", grid, 32'h0);
        chk("drain_rst_busy", 32'(busy), 32'h0);
        chk("drain_rst_ready", 32'(box_ready), 32'h0);
        chk("drain_rst_hcount", 32'(hazard_count), 32'h0);

        for (int i = 0; i < 50 && (exq.size() > 0 || bq.size() > 0); i++)
            @(negedge clk);
        chk("pending_grid_valid", exq.size(), 0);
        chk("pending_bad_box", bq.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
